fir_fold_mac_seq: RTL and testbench



---
 rtl/fir_fold_mac_seq.sv | 177 +++++++++++++++++
 tb/tb_fir_fold_mac_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_fold_mac_seq.sv
// Tap sequencer and accumulator for a folded FIR built around one shared external multiplier.
// Define FIR_FOLD_SAT_FLAG_EN to add the sat_flag output, which marks clamped samples.
module fir_fold_mac_seq #(
    parameter int NTAPS     = 16,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 11,
    parameter int PROD_W    = 27,
    parameter int ACC_W     = 32,
    parameter int OUT_SHIFT = 10
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic [DATA_W-1:0]         in_tdata,
    input  logic                      in_tvalid,
    output logic                      in_tready,
    output logic [DATA_W-1:0]         out_tdata,
    output logic                      out_tvalid,
    input  logic                      out_tready,
    input  logic                      coef_we,
    input  logic [$clog2(NTAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]         coef_wdata,
    output logic                      coef_drop,
    output logic [DATA_W-1:0]         mul_din0,
    output logic [COEF_W-1:0]         mul_din1,
    input  logic [PROD_W-1:0]         mul_dout
`ifdef FIR_FOLD_SAT_FLAG_EN
    ,
    output logic                      sat_flag
`endif
);

    localparam int IDX_W = $clog2(NTAPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAPS - 1);
    localparam logic signed [ACC_W:0] HALF    = (ACC_W + 1)'(1) << (OUT_SHIFT - 1);
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

    state_t                   state_reg, state_next;
    logic [IDX_W-1:0]         idx_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [PROD_W-1:0] prod_reg;
    logic signed [DATA_W-1:0] dline_reg [NTAPS];
    logic signed [COEF_W-1:0] coef_reg  [NTAPS];
    logic [NTAPS-1:0]         coef_wr_en;

    logic                     accept;
    logic signed [ACC_W:0]    final_sum;
    logic signed [ACC_W:0]    shifted;
    logic [DATA_W-1:0]        sat_value;
    logic                     sat_hit;

    assign accept = (state_reg == IDLE) && in_tvalid;

    // One-hot decode of the coefficient write; only honoured while idle.
    genvar gi;
    generate
        for (gi = 0; gi < NTAPS; gi++) begin : g_coef_dec
            assign coef_wr_en[gi] = coef_we && (state_reg == IDLE) && (coef_addr == IDX_W'(gi));
        end
    endgenerate

    // State register
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_tvalid) state_next = MAC;
            MAC:     if (idx_reg == LAST_IDX) state_next = DRAIN;
            DRAIN:   state_next = OUT;
            OUT:     if (out_tready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: multiplier operands are only driven while taps are being issued
    always_comb begin
        in_tready = 1'b0;
        mul_din0  = '0;
        mul_din1  = '0;
        case (state_reg)
            IDLE: in_tready = 1'b1;
            MAC: begin
                mul_din0 = dline_reg[idx_reg];
                mul_din1 = coef_reg[idx_reg];
            end
            default: ;
        endcase
    end

    // Final sum includes the last product still sitting in prod_reg; one guard bit absorbs rounding.
    always_comb begin
        final_sum = {acc_reg[ACC_W-1], acc_reg}
                  + {{(ACC_W + 1 - PROD_W){prod_reg[PROD_W-1]}}, prod_reg};
        shifted   = (final_sum + HALF) >>> OUT_SHIFT;
        sat_hit   = 1'b0;
        sat_value = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_value = SAT_MAX[DATA_W-1:0];
            sat_hit   = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat_value = SAT_MIN[DATA_W-1:0];
            sat_hit   = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                dline_reg[k] <= '0;
                coef_reg[k]  <= '0;
            end
            coef_drop <= 1'b0;
        end else begin
            if (accept) begin
                dline_reg[0] <= in_tdata;
                for (int k = 1; k < NTAPS; k++) dline_reg[k] <= dline_reg[k-1];
            end
            for (int k = 0; k < NTAPS; k++) begin
                if (coef_wr_en[k]) coef_reg[k] <= coef_wdata;
            end
            if (coef_we && state_reg != IDLE) coef_drop <= 1'b1;
        end
    end

    // Product is registered, so accumulation lags the issued tap by one edge.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            idx_reg    <= '0;
            acc_reg    <= '0;
            prod_reg   <= '0;
            out_tdata  <= '0;
            out_tvalid <= 1'b0;
`ifdef FIR_FOLD_SAT_FLAG_EN
            sat_flag   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_tvalid) begin
                        idx_reg <= '0;
                        acc_reg <= '0;
                    end
                end
                MAC: begin
                    prod_reg <= mul_dout;
                    idx_reg  <= idx_reg + IDX_W'(1);
                    if (idx_reg != '0)
                        acc_reg <= acc_reg + {{(ACC_W - PROD_W){prod_reg[PROD_W-1]}}, prod_reg};
                end
                DRAIN: begin
                    out_tdata  <= sat_value;
                    out_tvalid <= 1'b1;
`ifdef FIR_FOLD_SAT_FLAG_EN
                    sat_flag   <= sat_hit;
`endif
                end
                OUT: begin
                    if (out_tready) out_tvalid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifndef FIR_FOLD_SAT_FLAG_EN
    logic unused_sat;
    assign unused_sat = sat_hit;
`endif

endmodule

// File: tb/tb_fir_fold_mac_seq.sv
// Randomized self-checking bench for fir_fold_mac_seq against a sum-of-products reference.
// Supplies the combinational multiplier and exercises impulse, rounding, saturation, backpressure and reset.
module tb_fir_fold_mac_seq;
    localparam int NTAPS     = 16;
    localparam int DATA_W    = 16;
    localparam int COEF_W    = 11;
    localparam int PROD_W    = 27;
    localparam int ACC_W     = 32;
    localparam int OUT_SHIFT = 10;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic [DATA_W-1:0] in_tdata;
    logic              in_tvalid;
    logic              in_tready;
    logic [DATA_W-1:0] out_tdata;
    logic              out_tvalid;
    logic              out_tready;
    logic              coef_we;
    logic [3:0]        coef_addr;
    logic [COEF_W-1:0] coef_wdata;
    logic              coef_drop;
    logic [DATA_W-1:0] mul_din0;
    logic [COEF_W-1:0] mul_din1;
    logic [PROD_W-1:0] mul_dout;
`ifdef FIR_FOLD_SAT_FLAG_EN
    logic              sat_flag;
`endif

    fir_fold_mac_seq #(
        .NTAPS(NTAPS), .DATA_W(DATA_W), .COEF_W(COEF_W),
        .PROD_W(PROD_W), .ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .coef_drop(coef_drop),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout)
`ifdef FIR_FOLD_SAT_FLAG_EN
        , .sat_flag(sat_flag)
`endif
    );

    assign mul_dout = $signed(mul_din0) * $signed(mul_din1);

    always #5 ap_clk = ~ap_clk;

    longint dl [NTAPS];
    longint cf [NTAPS];
    int     n_vec = 0;
    int     n_err = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp_v);
        n_vec++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
        end
    endtask

    // Filter output as a plain sum of products, rounded half up and clamped.
    function automatic longint model_out(output bit clamped);
        longint s = 0;
        for (int k = 0; k < NTAPS; k++) s += dl[k] * cf[k];
        s = (s + (longint'(1) << (OUT_SHIFT - 1))) >>> OUT_SHIFT;
        clamped = 1'b0;
        if (s > 32767)       begin s = 32767;  clamped = 1'b1; end
        else if (s < -32768) begin s = -32768; clamped = 1'b1; end
        return s;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NTAPS; k++) begin
            dl[k] = 0;
            cf[k] = 0;
        end
    endtask

    task automatic write_coef(input int addr, input int val);
        @(negedge ap_clk);
        coef_we    = 1'b1;
        coef_addr  = addr[3:0];
        coef_wdata = val[COEF_W-1:0];
        @(posedge ap_clk);
        #1;
        coef_we = 1'b0;
        cf[addr] = val;
    endtask

    // One complete transaction: accept, wait for the result, optional stall, then handshake.
    task automatic send_sample(input int x, input int stall, input bit inject, output longint obs);
        longint        exp_v;
        bit            exp_clamp;
        int            lat;
        logic [DATA_W-1:0] held;
        @(negedge ap_clk);
        in_tdata  = x[DATA_W-1:0];
        in_tvalid = 1'b1;
        check_eq("in_tready_idle", longint'(in_tready), 1);
        @(posedge ap_clk);
        #1;
        in_tvalid = 1'b0;
        for (int k = NTAPS - 1; k > 0; k--) dl[k] = dl[k-1];
        dl[0] = x;
        exp_v = model_out(exp_clamp);
        check_eq("in_tready_busy", longint'(in_tready), 0);
        lat = 0;
        while (!out_tvalid && lat < 64) begin
            if (inject && lat == 5) begin
                coef_we    = 1'b1;
                coef_addr  = 4'd0;
                coef_wdata = 11'd500;
            end else begin
                coef_we = 1'b0;
            end
            @(posedge ap_clk);
            #1;
            lat++;
        end
        coef_we = 1'b0;
        check_eq("latency", longint'(lat), NTAPS + 1);
        obs = longint'($signed(out_tdata));
        check_eq("out_tdata", obs, exp_v);
`ifdef FIR_FOLD_SAT_FLAG_EN
        check_eq("sat_flag", longint'(sat_flag), longint'(exp_clamp));
`endif
        if (inject) check_eq("coef_drop_set", longint'(coef_drop), 1);
        held = out_tdata;
        for (int c = 0; c < stall; c++) begin
            @(negedge ap_clk);
            in_tvalid = 1'b1;
            @(posedge ap_clk);
            #1;
            check_eq("stall_valid", longint'(out_tvalid), 1);
            check_eq("stall_data", longint'(out_tdata), longint'(held));
            check_eq("stall_in_tready", longint'(in_tready), 0);
        end
        @(negedge ap_clk);
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
        @(posedge ap_clk);
        #1;
        out_tready = 1'b0;
        check_eq("handshake_valid_low", longint'(out_tvalid), 0);
        check_eq("handshake_in_tready", longint'(in_tready), 1);
        $display("sample in=%0d out=%0d exp=%0d lat=%0d stall=%0d", x, obs, exp_v, lat, stall);
    endtask

    task automatic load_impulse_coefs();
        for (int k = 0; k < NTAPS; k++) write_coef(k, 60 * (k + 1));
    endtask

    task automatic run_impulse(input string tag);
        longint obs;
        send_sample(1024, 0, 0, obs);
        check_eq(tag, obs, 60);
        for (int i = 1; i <= NTAPS; i++) begin
            send_sample(0, 0, 0, obs);
            check_eq(tag, obs, (i < NTAPS) ? 60 * (i + 1) : 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint obs;
        int     rx;
        int     round_in  [4] = '{512, -512, 1536, -1536};
        int     round_exp [4] = '{1, 0, 2, -1};

        ap_rst = 1'b1; in_tdata = '0; in_tvalid = 1'b0; out_tready = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        model_clear();
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        check_eq("rst_out_tvalid", longint'(out_tvalid), 0);
        check_eq("rst_out_tdata", longint'(out_tdata), 0);
        check_eq("rst_in_tready", longint'(in_tready), 1);
        check_eq("rst_coef_drop", longint'(coef_drop), 0);
        check_eq("rst_mul_din0", longint'(mul_din0), 0);
        check_eq("rst_mul_din1", longint'(mul_din1), 0);

        load_impulse_coefs();
        run_impulse("impulse");

        for (int k = 0; k < NTAPS; k++) write_coef(k, (k == 0) ? 1 : 0);
        for (int i = 0; i < 4; i++) begin
            send_sample(round_in[i], 0, 0, obs);
            check_eq("rounding", obs, longint'(round_exp[i]));
        end

        for (int k = 0; k < NTAPS; k++) write_coef(k, 1023);
        for (int i = 0; i < NTAPS; i++) send_sample(32767, 0, 0, obs);
        check_eq("sat_pos", obs, 32767);
        for (int i = 0; i < NTAPS; i++) send_sample(-32768, 0, 0, obs);
        check_eq("sat_neg", obs, -32768);

        for (int k = 0; k < NTAPS; k++) write_coef(k, int'($urandom_range(0, 2047)) - 1024);
        send_sample(int'($urandom_range(0, 65535)) - 32768, 20, 0, obs);

        // Write during MAC must be dropped; the next sample still sees the old coefficients.
        send_sample(int'($urandom_range(0, 65535)) - 32768, 0, 1, obs);
        send_sample(int'($urandom_range(0, 65535)) - 32768, 0, 0, obs);

        for (int i = 0; i < 30; i++) begin
            if (i % 10 == 0)
                for (int k = 0; k < NTAPS; k++) write_coef(k, int'($urandom_range(0, 2047)) - 1024);
            rx = int'($urandom_range(0, 65535)) - 32768;
            send_sample(rx, int'($urandom_range(0, 3)), 0, obs);
        end

        // Abandon a sample with idx at 7, then confirm a clean impulse response.
        @(negedge ap_clk);
        in_tdata  = 16'd20000;
        in_tvalid = 1'b1;
        @(posedge ap_clk);
        #1;
        in_tvalid = 1'b0;
        repeat (7) @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        #1;
        check_eq("midrst_out_tvalid", longint'(out_tvalid), 0);
        check_eq("midrst_in_tready", longint'(in_tready), 1);
        check_eq("midrst_coef_drop", longint'(coef_drop), 0);
        check_eq("midrst_mul_din0", longint'(mul_din0), 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        model_clear();
        load_impulse_coefs();
        run_impulse("impulse_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
